fetch_stage: RTL and testbench

//   Instruction fetch stage; sits directly upstream of decode.

---
 rtl/core_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/fetch_stage.sv | 146 ++++++++++++++
 tb/tb_fetch_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the instruction fetch path: the buffered {pc, instr}
// pair and the instruction size used for sequential PC stepping.
package core_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. Pointers carry one extra bit so
// full and empty are distinguishable; the head is read combinationally so
// decode sees a buffered entry with no added latency. Flush empties it.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          empty,
  output fetch_entry_t  head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  fetch_entry_t mem_reg [DEPTH];

  // Pointer update; flush discards everything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Entry storage; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_reg[wr_ptr_reg[AW-1:0]] <= push_entry;
  end

  assign count = CW'(wr_ptr_reg - rd_ptr_reg);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign head  = mem_reg[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage feeding decode. Issues in-order word requests to
// instruction memory under a credit limit (in-flight + buffered never
// exceeds FIFO_DEPTH), buffers returned {pc, instr} pairs and presents them
// with valid/ready. A redirect from decode flushes the buffer, restarts at
// the branch target and drops responses still in flight.
// Optional build macro: FETCH_PERF_EN adds perf_fetched / perf_flushes.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_nextpc,
  output logic [31:0] if_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushes
`endif
);

  localparam int            CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   rsp_pc_reg, rsp_pc_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_target;
  logic          req_fire;
  logic          rsp_push;
  logic          fifo_pop;
  logic          fifo_empty;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // One extra bit so the sum of in-flight and buffered work cannot wrap.
  assign credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count};

  // Requests are held off while in reset and in the redirect cycle.
  assign imem_req_valid = rst_n && !redirect_valid &&
                          (credit_used < (CW + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = rst_n ? fetch_pc_reg : 32'h0;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign if_valid  = !fifo_empty && !redirect_valid;
  assign fifo_pop  = if_valid && if_ready;
  assign if_pc     = fifo_empty ? 32'h0 : head_entry.pc;
  assign if_instr  = fifo_empty ? 32'h0 : head_entry.instr;
  assign if_nextpc = fifo_empty ? 32'h0 : next_pc(head_entry.pc);

  // The response PC is implied by request order, so it is tracked here
  // rather than carried through instruction memory.
  assign push_entry = '{pc: rsp_pc_reg, instr: imem_rsp_data};

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (rsp_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .count      (fifo_count),
    .empty      (fifo_empty),
    .head       (head_entry)
  );

  // Next-state for the fetch PC, response PC and in-flight bookkeeping.
  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    rsp_pc_next      = rsp_pc_reg;
    drop_cnt_next    = drop_cnt_reg;
    rsp_push         = 1'b0;
    outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      // Everything still in flight after this cycle is wrong-path; a
      // response landing in this very cycle is discarded outright.
      fetch_pc_next = redirect_target;
      rsp_pc_next   = redirect_target;
      drop_cnt_next = outstanding_next;
    end else begin
      if (req_fire) fetch_pc_next = next_pc(fetch_pc_reg);
      if (imem_rsp_valid) begin
        if (drop_cnt_reg != '0) begin
          drop_cnt_next = drop_cnt_reg - ONE;
        end else begin
          rsp_push    = 1'b1;
          rsp_pc_next = next_pc(rsp_pc_reg);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_flushes_reg;

  // Delivered-instruction and redirect counters; free-running, wrap at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_reg <= '0;
      perf_flushes_reg <= '0;
    end else begin
      perf_fetched_reg <= perf_fetched_reg + 32'(fifo_pop);
      perf_flushes_reg <= perf_flushes_reg + 32'(redirect_valid);
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_flushes = perf_flushes_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural instruction memory with configurable
// response latency and optional random request backpressure, a stimulus
// process that queues the expected PC stream per scenario, and a monitor
// that checks every delivered instruction and every request address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_nextpc;
  logic [31:0] if_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  bit rand_ready = 1'b0;
  int req_count = 0;
  int pops = 0;
  logic [31:0] exp_req_addr = 32'h0;
  logic [31:0] exp_q[$];
  int          pend_due[$];
  logic [31:0] pend_addr[$];

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_nextpc      (if_nextpc),
    .if_instr       (if_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushes   (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return addr ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Instruction memory: accepts on handshake, answers in order after lat cycles.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_req_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        pend_due.push_back(cyc + lat);
        pend_addr.push_back(imem_req_addr);
      end
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pend_due.delete();
        pend_addr.delete();
        imem_rsp_valid = 1'b0;
      end else if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(pend_addr[0]);
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: request-address model, redirect gating, delivery scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_req_addr = 32'h0;
    end else begin
      if (redirect_valid) begin
        chk(32'(imem_req_valid), 32'h0, "req_valid_in_redirect");
        chk(32'(if_valid), 32'h0, "if_valid_in_redirect");
        exp_req_addr = {redirect_pc[31:2], 2'b00};
      end
      if (imem_req_valid && imem_req_ready) begin
        $display("req  addr=0x%08h", imem_req_addr);
        chk(imem_req_addr, exp_req_addr, "req_addr");
        exp_req_addr = exp_req_addr + 32'd4;
        req_count++;
      end
      if (if_valid && if_ready) begin
        pops++;
        $display("deliver pc=0x%08h next=0x%08h instr=0x%08h", if_pc, if_nextpc, if_instr);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got pc 0x%08h, none expected", if_pc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk(if_pc, e, "if_pc");
          chk(if_nextpc, e + 32'd4, "if_nextpc");
          chk(if_instr, instr_of(e), "if_instr");
        end
      end
    end
  end

  // Hold if_ready until every expected entry is delivered, then drop it.
  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d entries outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    if_ready = 1'b0;
  endtask

  task automatic push_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  initial begin
    int req_base;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(32'(imem_req_valid), 32'h0, "rst_req_valid");
    chk(32'(if_valid), 32'h0, "rst_if_valid");
    chk(imem_req_addr, 32'h0, "rst_req_addr");
    chk(if_pc, 32'h0, "rst_if_pc");
    chk(if_nextpc, 32'h0, "rst_if_nextpc");
    chk(if_instr, 32'h0, "rst_if_instr");

    // Release with decode ready: first delivery two cycles after release.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    if_ready = 1'b1;
    push_run(32'h0, 3);
    @(negedge clk);
    chk(32'(imem_req_valid), 32'h1, "c0_req_valid");
    chk(imem_req_addr, 32'h0, "c0_req_addr");
    @(negedge clk);
    @(negedge clk);
    chk(32'(if_valid), 32'h1, "c2_if_valid");
    chk(if_pc, 32'h0, "c2_if_pc");
    drain(50);

    // Decode stalled: buffer fills and requests stop.
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk(32'(imem_req_valid), 32'h0, "full_req_valid");
    chk(32'(if_valid), 32'h1, "full_if_valid");
    chk(if_pc, 32'h0000_000C, "full_head_pc");
    chk(32'(req_count), 32'd7, "full_req_count");

    // Reset mid-flight, then release with decode stalled.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk(32'(if_valid), 32'h0, "midrst_if_valid");
    chk(32'(imem_req_valid), 32'h0, "midrst_req_valid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_base = req_count;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk(32'(req_count - req_base), 32'd4, "stall_req_count");
    chk(32'(imem_req_valid), 32'h0, "stall_req_valid");
    chk(if_pc, 32'h0, "stall_head_pc");
    chk(if_instr, instr_of(32'h0), "stall_head_instr");
    push_run(32'h0, 6);
    @(posedge clk);
    #1;
    if_ready = 1'b1;
    drain(50);

    // Slow memory: redirect to 0x40, then to 0x100 with two requests in flight.
    lat = 3;
    repeat (8) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    if_ready       = 1'b1;
    push_run(32'h0000_0100, 3);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    drain(100);

    // Back-to-back redirects with work in flight; unaligned target.
    repeat (2) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    @(posedge clk);
    #1;
    redirect_pc    = 32'h0000_0203;
    if_ready       = 1'b1;
    push_run(32'h0000_0200, 4);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    drain(100);

    // Random request backpressure across the address wrap.
    rand_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF0;
    if_ready       = 1'b1;
    push_run(32'hFFFF_FFF0, 10);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    drain(400);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk(32'(pops), 32'd26, "total_deliveries");
`ifdef FETCH_PERF_EN
    chk(perf_fetched, 32'd23, "perf_fetched");
    chk(perf_flushes, 32'd5, "perf_flushes");
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, required finish before 300000");
    $fatal(1, "watchdog expired");
  end

endmodule
